systolic_result_drain: RTL and testbench

Downstream stage of the systolic MAC array. It waits until every PE in a ROWS×COLS array reports a finished dot product, then snapshots all accumulators in one cycle and pulses a one-cycle clear back to the array. It then streams the results out in row-major order over a valid/ready interface, saturating each from ACC_WIDTH to OUT_WIDTH. The array can start its next tile while the previous tile is still draining.

---
 rtl/systolic_result_drain.sv | 157 +++++++++++++++
 tb/tb_systolic_result_drain.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Drains one tile of results from a ROWS x COLS systolic MAC array. It waits
// until every PE reports done, snapshots all accumulators into a local buffer
// in one cycle, pulses array_clear for one cycle, and then streams the buffer
// out in row-major order over a valid/ready interface. Each word is saturated
// from ACC_WIDTH to OUT_WIDTH. While a tile drains, the array can already work
// on the next tile, because the buffer is written only on capture.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   acc_value_flat  PE accumulators, PE (r,c) at [(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH]
//   acc_valid_flat  PE done flags, bit r*COLS+c
//   array_clear     one-cycle clear pulse back to the PEs
//   out_data        saturated result (signed, OUT_WIDTH bits)
//   out_sat         out_data was clamped
//   out_row/out_col row/column of the presented element
//   out_last        presented element is the last of the tile
//   out_valid       element valid
//   out_ready       consumer accepts the element
//   busy            high while clearing or streaming
// -----------------------------------------------------------------------------
module systolic_result_drain #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int N_PE     = ROWS * COLS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_PE*ACC_WIDTH-1:0]     acc_value_flat,
   input  logic [N_PE-1:0]               acc_valid_flat,
   output logic                          array_clear,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_sat,
   output logic [ROW_W-1:0]              out_row,
   output logic [COL_W-1:0]              out_col,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy
);

   localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

   state_t                      state;
   logic [IDX_W-1:0]            idx;
   logic [ROW_W-1:0]            row;
   logic [COL_W-1:0]            col;
   logic signed [ACC_WIDTH-1:0] buffer [N_PE];

   logic                        all_valid;
   logic                        capture;
   logic                        accept;
   logic                        last_elem;
   logic [OUT_WIDTH:0]          sat_word;

   // Clamp a signed accumulator to OUT_WIDTH. The word fits exactly when all
   // bits from the sign bit down to bit OUT_WIDTH-1 agree; otherwise clamp
   // towards the sign of the original value. Returns {sat, data}.
   function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
      logic [ACC_WIDTH-OUT_WIDTH:0] top;
      top = v[ACC_WIDTH-1:OUT_WIDTH-1];
      if ((&top) || !(|top))
         return {1'b0, v[OUT_WIDTH-1:0]};
      else if (v[ACC_WIDTH-1])
         return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
   endfunction

   assign all_valid = &acc_valid_flat;
   assign capture   = (state == IDLE) && all_valid;
   assign accept    = out_valid && out_ready;
   assign last_elem = (row == ROW_W'(ROWS-1)) && (col == COL_W'(COLS-1));

   // Stage boundary: buffer capture. Data only, so no reset; written solely on
   // capture so array activity during a drain cannot disturb it.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < N_PE; i++)
            buffer[i] <= acc_value_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
   end

   // Stage boundary: control FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         row         <= '0;
         col         <= '0;
         array_clear <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         array_clear <= 1'b0;
         case (state)
            IDLE: begin
               if (capture) begin
                  state       <= CLEAR;
                  idx         <= '0;
                  row         <= '0;
                  col         <= '0;
                  array_clear <= 1'b1;
                  out_valid   <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            CLEAR, STREAM: begin
               state <= STREAM;
               if (accept) begin
                  // Row/col counters run alongside the flat index so no divide
                  // is needed; both wrap to zero after the last element.
                  if (last_elem) begin
                     state     <= IDLE;
                     idx       <= '0;
                     row       <= '0;
                     col       <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                     if (col == COL_W'(COLS-1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Outputs are forced to zero when nothing is presented, so the unreset
   // buffer never leaks onto the bus.
   assign sat_word = saturate(buffer[idx]);
   assign out_data = out_valid ? $signed(sat_word[OUT_WIDTH-1:0]) : '0;
   assign out_sat  = out_valid & sat_word[OUT_WIDTH];
   assign out_row  = row;
   assign out_col  = col;
   assign out_last = out_valid & last_elem;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

   localparam int R  = 2;
   localparam int C  = 2;
   localparam int AW = 32;
   localparam int OW = 16;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [R*C*AW-1:0]         acc_value_flat = '0;
   logic [R*C-1:0]            acc_valid_flat = '0;
   logic                      array_clear;
   logic signed [OW-1:0]      out_data;
   logic                      out_sat;
   logic [0:0]                out_row;
   logic [0:0]                out_col;
   logic                      out_last;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
   logic                      busy;

   int n_cmp = 0;
   int n_err = 0;

   systolic_result_drain #(
      .ROWS(R), .COLS(C), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .acc_value_flat(acc_value_flat),
      .acc_valid_flat(acc_valid_flat),
      .array_clear(array_clear),
      .out_data(out_data),
      .out_sat(out_sat),
      .out_row(out_row),
      .out_col(out_col),
      .out_last(out_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
      acc_value_flat = {d, c, b, a};
   endtask

   task automatic check_elem(input string tag, input logic clr, input logic [15:0] d,
                             input logic sat, input logic r, input logic c, input logic last);
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".busy"},  {31'b0, busy}, 32'd1);
      check({tag, ".clear"}, {31'b0, array_clear}, {31'b0, clr});
      check({tag, ".data"},  {16'b0, out_data}, {16'b0, d});
      check({tag, ".sat"},   {31'b0, out_sat}, {31'b0, sat});
      check({tag, ".row"},   {31'b0, out_row}, {31'b0, r});
      check({tag, ".col"},   {31'b0, out_col}, {31'b0, c});
      check({tag, ".last"},  {31'b0, out_last}, {31'b0, last});
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".busy"},  {31'b0, busy}, 32'd0);
      check({tag, ".clear"}, {31'b0, array_clear}, 32'd0);
      check({tag, ".last"},  {31'b0, out_last}, 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check_idle("rst");
      check("rst.data", {16'b0, out_data}, 32'd0);
      check("rst.sat",  {31'b0, out_sat}, 32'd0);
      check("rst.row",  {31'b0, out_row}, 32'd0);
      check("rst.col",  {31'b0, out_col}, 32'd0);
      rst = 1'b0;
      tick();
      check_idle("rst_rel");

      // 1: basic drain
      out_ready = 1'b1;
      load(1, 2, 3, 4);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t1.e0", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      check_elem("t1.e1", 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_elem("t1.e2", 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t1.e3", 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t1.end");

      // 2: backpressure on element 1
      load(1, 2, 3, 4);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t2.e0", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      out_ready = 1'b0;
      check_elem("t2.e1", 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_elem("t2.hold", 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      check_elem("t2.e2", 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t2.e3", 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t2.end");

      // 3: saturation
      load(32'd40000, 32'hFFFF_63C0, 32'd32767, 32'hFFFF_8000);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t3.e0", 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      check_elem("t3.e1", 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check_elem("t3.e2", 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t3.e3", 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t3.end");

      // 4: partial valid
      load(20, 21, 22, 23);
      acc_valid_flat = 4'b0111;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4.valid", {31'b0, out_valid}, 32'd0);
         check("t4.clear", {31'b0, array_clear}, 32'd0);
      end
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t4.e0", 1'b1, 16'd20, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      check_elem("t4.e1", 1'b0, 16'd21, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      check_elem("t4.e3", 1'b0, 16'd23, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t4.end");

      // 5: reset mid-stream after two handshakes
      load(1, 2, 3, 4);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t5.e0", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      tick();
      check_elem("t5.e2", 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("t5.rst");
      check("t5.rst.row", {31'b0, out_row}, 32'd0);
      check("t5.rst.col", {31'b0, out_col}, 32'd0);
      load(5, 6, 7, 8);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t5.f0", 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      check_elem("t5.f1", 1'b0, 16'd6, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_elem("t5.f2", 1'b0, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t5.f3", 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t5.end");

      // 6: next tile completes during the drain
      load(1, 2, 3, 4);
      acc_valid_flat = 4'hF;
      tick();
      check_elem("t6.a0", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      load(9, 10, 11, 12);
      check_elem("t6.a1", 1'b0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      acc_valid_flat = 4'hF;
      check_elem("t6.a2", 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t6.a3", 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t6.gap");
      tick();
      check_elem("t6.b0", 1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      acc_valid_flat = 4'h0;
      check_elem("t6.b1", 1'b0, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      check_elem("t6.b2", 1'b0, 16'd11, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_elem("t6.b3", 1'b0, 16'd12, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("t6.end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
